// File: rtl/rotate_multi.sv
// Rotating-shape driver for an active-low DIGITS-wide seven-segment display: square rotation or perimeter chase.
// Define ROTATE_LAP_EN to add the one-cycle lap output that pulses when the position wraps.
module rotate_multi #(
    parameter int DIGITS = 4,
    parameter int POWER  = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clockwise,
    input  logic              mode,
    output logic [7:0]        sseg_pattern,
    output logic [DIGITS-1:0] an
`ifdef ROTATE_LAP_EN
    ,
    output logic              lap
`endif
);

    localparam int PW = $clog2(2*DIGITS + 4);
    localparam logic [PW-1:0] LAST_SQUARE = PW'(2*DIGITS - 1);
    localparam logic [PW-1:0] LAST_CHASE  = PW'(2*DIGITS + 3);

    logic [POWER-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic              mode_q;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              tick;
    logic              mode_chg;
    logic [PW-1:0]     last_pos;
    int                dec_pos;
    int                dec_dig;
    logic [7:0]        dec_pat;

    assign mode_chg = (mode != mode_q);
    assign tick     = enable && (cnt_q == '1);
    assign last_pos = mode_q ? LAST_CHASE : LAST_SQUARE;

    // A mode change restarts the animation and outranks a coincident tick.
    always_comb begin
        cnt_d = cnt_q;
        pos_d = pos_q;
        if (mode_chg) begin
            cnt_d = '0;
            pos_d = '0;
        end else begin
            if (enable)
                cnt_d = cnt_q + 1'b1;
            if (tick) begin
                if (clockwise)
                    pos_d = (pos_q == last_pos) ? '0 : pos_q + 1'b1;
                else
                    pos_d = (pos_q == '0) ? last_pos : pos_q - 1'b1;
            end
        end
    end

    always_comb begin
        dec_pos = int'(pos_q);
        dec_dig = -1;
        dec_pat = 8'hFF;
        if (!mode_q) begin
            if (dec_pos < DIGITS) begin
                dec_pat = 8'h9C;
                dec_dig = DIGITS - 1 - dec_pos;
            end else if (dec_pos < 2*DIGITS) begin
                dec_pat = 8'hA3;
                dec_dig = dec_pos - DIGITS;
            end
        end else begin
            if (dec_pos < DIGITS) begin
                dec_pat = 8'hFE;
                dec_dig = DIGITS - 1 - dec_pos;
            end else if (dec_pos == DIGITS) begin
                dec_pat = 8'hFD;
                dec_dig = 0;
            end else if (dec_pos == DIGITS + 1) begin
                dec_pat = 8'hFB;
                dec_dig = 0;
            end else if (dec_pos < 2*DIGITS + 2) begin
                dec_pat = 8'hF7;
                dec_dig = dec_pos - DIGITS - 2;
            end else if (dec_pos == 2*DIGITS + 2) begin
                dec_pat = 8'hEF;
                dec_dig = DIGITS - 1;
            end else if (dec_pos == 2*DIGITS + 3) begin
                dec_pat = 8'hDF;
                dec_dig = DIGITS - 1;
            end
        end
        seg_d = dec_pat;
        an_d  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == dec_dig)
                an_d[k] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            mode_q <= mode;
            seg_q  <= 8'hFF;
            an_q   <= '1;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            mode_q <= mode;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign sseg_pattern = seg_q;
    assign an           = an_q;

`ifdef ROTATE_LAP_EN
    logic wrap_d, wrap_q, lap_q;

    // Delayed one extra stage so the pulse lines up with the decoded outputs.
    assign wrap_d = tick && !mode_chg &&
                    (clockwise ? (pos_q == last_pos) : (pos_q == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
            lap_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            lap_q  <= wrap_q;
        end
    end

    assign lap = lap_q;
`endif

endmodule

// File: tb/tb_rotate_multi.sv
// Scoreboard bench for rotate_multi (DIGITS=4, POWER=1); lap is also checked when ROTATE_LAP_EN is defined.
module tb_rotate_multi;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic       lap;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clockwise;
    logic       mode;
    logic [7:0] sseg_pattern;
    logic [3:0] an;
`ifdef ROTATE_LAP_EN
    logic       lap;
`endif

    exp_t sb_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    logic [7:0] sq_seg [0:7]  = '{8'h9C, 8'h9C, 8'h9C, 8'h9C, 8'hA3, 8'hA3, 8'hA3, 8'hA3};
    logic [3:0] sq_an  [0:7]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110,
                                  4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] ch_seg [0:11] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFD, 8'hFB,
                                  8'hF7, 8'hF7, 8'hF7, 8'hF7, 8'hEF, 8'hDF};
    logic [3:0] ch_an  [0:11] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1110,
                                  4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b0111};

    rotate_multi #(.DIGITS(4), .POWER(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clockwise    (clockwise),
        .mode         (mode),
        .sseg_pattern (sseg_pattern),
        .an           (an)
`ifdef ROTATE_LAP_EN
        ,
        .lap          (lap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        check_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("[TB] FAIL %s (check %0d): got %h, expected %h", name, check_cnt, act, exp);
    endtask

    // Push the expected output for the edge that has just occurred.
    task automatic apply_stimulus(input exp_t e);
        @(posedge clk);
        #1;
        sb_q.push_back(e);
    endtask

    function automatic exp_t lookup(input logic m, input int p, input logic l);
        exp_t e;
        e.seg = m ? ch_seg[p] : sq_seg[p];
        e.an  = m ? ch_an[p]  : sq_an[p];
        e.lap = l;
        return e;
    endfunction

    // Each position is displayed for two cycles; lap can only be high on the first.
    task automatic show_pos(input logic m, input int p, input logic l);
        apply_stimulus(lookup(m, p, l));
        apply_stimulus(lookup(m, p, 1'b0));
    endtask

    task automatic do_reset(input logic new_mode, input logic new_cw);
        exp_t blank;
        blank.seg = 8'hFF;
        blank.an  = 4'b1111;
        blank.lap = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mode      = new_mode;
        clockwise = new_cw;
        sb_q.push_back(blank);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_output("sseg_pattern", sseg_pattern, e.seg);
            check_output("an", {4'b0000, an}, {4'b0000, e.an});
`ifdef ROTATE_LAP_EN
            check_output("lap", {7'b0, lap}, {7'b0, e.lap});
`endif
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        clockwise = 1'b1;
        mode      = 1'b0;

        // Square rotation clockwise through one full lap and back to the start.
        do_reset(1'b0, 1'b1);
        for (int p = 0; p < 8; p++)
            show_pos(1'b0, p, 1'b0);
        show_pos(1'b0, 0, 1'b1);
        show_pos(1'b0, 1, 1'b0);

        // Freeze mid-step for 20 cycles, then resume from the held position.
        apply_stimulus(lookup(1'b0, 2, 1'b0));
        enable = 1'b0;
        repeat (20) apply_stimulus(lookup(1'b0, 2, 1'b0));
        enable = 1'b1;
        apply_stimulus(lookup(1'b0, 2, 1'b0));
        for (int p = 3; p < 7; p++)
            show_pos(1'b0, p, 1'b0);

        // Mode switch coinciding with the 7->0 wrap tick: clears to 0 with no lap.
        apply_stimulus(lookup(1'b0, 7, 1'b0));
        mode = 1'b1;
        apply_stimulus(lookup(1'b0, 7, 1'b0));
        for (int p = 0; p < 12; p++)
            show_pos(1'b1, p, 1'b0);
        show_pos(1'b1, 0, 1'b1);
        show_pos(1'b1, 1, 1'b0);

        // Asynchronous reset mid-run, restart counter-clockwise in square mode.
        do_reset(1'b0, 1'b0);
        show_pos(1'b0, 0, 1'b0);
        show_pos(1'b0, 7, 1'b1);
        show_pos(1'b0, 6, 1'b0);
        show_pos(1'b0, 5, 1'b0);

        // Direction flip applies at the next tick without resetting position.
        clockwise = 1'b1;
        show_pos(1'b0, 4, 1'b0);
        show_pos(1'b0, 5, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        check_output("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #100000;
        check_cnt++;
        $display("[TB] FAIL timeout: got still running, expected finished");
        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
